// File: rtl/requant_scale.sv
// requant_scale: three-stage pipelined requantizer.
//   S1: sum  = sext(acc_in) + sext(bias)                  (ACC_WIDTH+1 bits)
//   S2: prod = sum * {1'b0, scale}                        (ACC_WIDTH+SCALE_WIDTH+2 bits)
//   S3: y    = sat_OUT_WIDTH((prod + 2^(shift-1)) >>> shift), or sat(prod) when shift == 0
// scale and shift travel with each word, so they may change every cycle.
// Valid/ready handshake on both sides; every stage advances when its
// successor is empty or advancing, giving 1 word/cycle and a 3-cycle latency.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid, in_ready  upstream handshake (in_ready has no path from in_valid)
//   acc_in, bias        signed accumulator and bias, ACC_WIDTH bits
//   scale               unsigned multiplier, SCALE_WIDTH bits
//   shift               right-shift amount, SHIFT_WIDTH bits
//   out_valid, out_ready downstream handshake
//   y                   signed saturated result, OUT_WIDTH bits
module requant_scale #(
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_WIDTH = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int OUT_WIDTH   = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ACC_WIDTH-1:0]   acc_in,
  input  logic [ACC_WIDTH-1:0]   bias,
  input  logic [SCALE_WIDTH-1:0] scale,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   y
);

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int PROD_W = ACC_WIDTH + SCALE_WIDTH + 2;
  localparam int RND_W  = PROD_W + 1;

  // Saturation bounds expressed at the rounding width.
  localparam logic signed [RND_W-1:0] Y_MAX =
    {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RND_W-1:0] Y_MIN =
    {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  // Stage registers
  logic                     v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [SUM_W-1:0]         sum_q, sum_d;
  logic [SCALE_WIDTH-1:0]   scale1_q, scale1_d;
  logic [SHIFT_WIDTH-1:0]   shift1_q, shift1_d, shift2_q, shift2_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic [OUT_WIDTH-1:0]     y_q, y_d;

  // Datapath intermediates
  logic                     adv1, adv2, adv3;
  logic signed [PROD_W-1:0] mul_a, mul_b, mul_p;
  logic signed [RND_W-1:0]  prod_ext, rnd_c, rnd_sum, r;
  logic [OUT_WIDTH-1:0]     y_sat;

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    // Advance chain runs back from the output; in_ready never sees in_valid.
    adv3     = ~v3_q | out_ready;
    adv2     = ~v2_q | adv3;
    adv1     = ~v1_q | adv2;
    in_ready = adv1;

    // S2 multiply: both operands widened to the product width so the
    // signed multiply is exact (the true product always fits).
    mul_a = {{(PROD_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};
    mul_b = {{(PROD_W-SCALE_WIDTH){1'b0}}, scale1_q};
    mul_p = mul_a * mul_b;

    // S3 round-half-up and arithmetic shift at prod width + 1.
    prod_ext = {prod_q[PROD_W-1], prod_q};
    rnd_c    = RND_W'(1) << (shift2_q - SHIFT_WIDTH'(1));
    rnd_sum  = prod_ext + rnd_c;
    if (shift2_q == '0) begin
      r = prod_ext;
    end else if (32'(shift2_q) > PROD_W) begin
      // |prod| < 2^(PROD_W-2), so any larger shift rounds to exactly 0;
      // this also keeps the rounding constant inside the adder width.
      r = '0;
    end else begin
      r = rnd_sum >>> shift2_q;
    end

    if (r > Y_MAX) begin
      y_sat = Y_MAX[OUT_WIDTH-1:0];
    end else if (r < Y_MIN) begin
      y_sat = Y_MIN[OUT_WIDTH-1:0];
    end else begin
      y_sat = r[OUT_WIDTH-1:0];
    end

    // Hold everything by default; a stage loads only when it advances.
    v1_d     = v1_q;
    sum_d    = sum_q;
    scale1_d = scale1_q;
    shift1_d = shift1_q;
    v2_d     = v2_q;
    prod_d   = prod_q;
    shift2_d = shift2_q;
    v3_d     = v3_q;
    y_d      = y_q;

    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        sum_d    = {acc_in[ACC_WIDTH-1], acc_in} + {bias[ACC_WIDTH-1], bias};
        scale1_d = scale;
        shift1_d = shift;
      end
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        prod_d   = mul_p;
        shift2_d = shift1_q;
      end
    end
    if (adv3) begin
      v3_d = v2_q;
      if (v2_q) begin
        y_d = y_sat;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  // NOTE: datapath registers are reset alongside the valids; it is cheap at
  // this size and keeps y at a defined 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sum_q    <= '0;
      scale1_q <= '0;
      shift1_q <= '0;
      prod_q   <= '0;
      shift2_q <= '0;
      y_q      <= '0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      sum_q    <= sum_d;
      scale1_q <= scale1_d;
      shift1_q <= shift1_d;
      prod_q   <= prod_d;
      shift2_q <= shift2_d;
      y_q      <= y_d;
    end
  end

  assign out_valid = v3_q;
  assign y         = y_q;

endmodule

// File: tb/tb_requant_scale.sv
// Testbench for requant_scale: directed scenarios plus randomized streams
// checked against an arithmetic reference model and an occupancy model.
module tb_requant_scale;

  localparam int ACC_W   = 32;
  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 6;
  localparam int OUT_W   = 21;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [ACC_W-1:0]  acc_in = '0;
  logic signed [ACC_W-1:0]  bias = '0;
  logic [SCALE_W-1:0]       scale = '0;
  logic [SHIFT_W-1:0]       shift = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [OUT_W-1:0]  y;

  int checks = 0;
  int errors = 0;

  // Words to send in the next stream, results collected from it.
  logic signed [ACC_W-1:0]  w_acc[$];
  logic signed [ACC_W-1:0]  w_bias[$];
  logic [SCALE_W-1:0]       w_scale[$];
  logic [SHIFT_W-1:0]       w_shift[$];
  logic signed [OUT_W-1:0]  got_y[$];
  logic                     saw_full;

  requant_scale #(
    .ACC_WIDTH(ACC_W), .SCALE_WIDTH(SCALE_W),
    .SHIFT_WIDTH(SHIFT_W), .OUT_WIDTH(OUT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .acc_in(acc_in), .bias(bias), .scale(scale), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, floor division by 2^shift after
  // adding half, then clamp to the signed OUT_W range.
  function automatic logic signed [OUT_W-1:0] ref_model(
      input longint a, input longint b, input longint s, input int sh);
    longint prod, r;
    prod = (a + b) * s;
    if (sh == 0) r = prod;
    else         r = (prod + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > 64'sd1048575)       r = 64'sd1048575;
    else if (r < -64'sd1048576) r = -64'sd1048576;
    return r[OUT_W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_words();
    w_acc.delete(); w_bias.delete(); w_scale.delete(); w_shift.delete();
    got_y.delete();
  endtask

  task automatic add_word(input longint a, input longint b,
                          input int s, input int sh);
    w_acc.push_back(ACC_W'(a));
    w_bias.push_back(ACC_W'(b));
    w_scale.push_back(SCALE_W'(s));
    w_shift.push_back(SHIFT_W'(sh));
  endtask

  // mode 0: out_ready=1, in_valid=1 while words remain
  // mode 1: out_ready pattern 1,0,0,0,0,1,0,1,1,1 then 1; in_valid=1
  // mode 2: random in_valid and out_ready
  task automatic run_stream(input int mode, input string tag, output int cycles);
    int pat[10] = '{1, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    logic signed [OUT_W-1:0] exp_q[$];
    logic signed [OUT_W-1:0] exp_y;
    logic signed [OUT_W-1:0] prev_y;
    logic prev_stall;
    logic exp_rdy;
    int n, sent, got, cyc, occ;
    n = w_acc.size();
    sent = 0; got = 0; cyc = 0; occ = 0;
    prev_stall = 1'b0; prev_y = '0;
    saw_full = 1'b0;
    got_y.delete();
    while (got < n && cyc < 5000) begin
      in_valid = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (sent < n) begin
        acc_in = w_acc[sent]; bias = w_bias[sent];
        scale = w_scale[sent]; shift = w_shift[sent];
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc < 10) ? (pat[cyc] != 0) : 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      @(negedge clk);
      // Pipeline of depth 3 accepts unless full and blocked downstream.
      exp_rdy = (occ < 3) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL %s in_ready cyc=%0d occ=%0d got=%b exp=%b",
                 tag, cyc, occ, in_ready, exp_rdy);
      end
      if (occ == 3 && !out_ready && in_ready === 1'b0) saw_full = 1'b1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || y !== prev_y) begin
          errors++;
          $display("FAIL %s stall_hold cyc=%0d out_valid=%b y=%0d exp y=%0d",
                   tag, cyc, out_valid, y, prev_y);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_output cyc=%0d y=%0d exp none", tag, cyc, y);
        end else begin
          exp_y = exp_q.pop_front();
          if (y !== exp_y) begin
            errors++;
            $display("FAIL %s y[%0d] got=%0d exp=%0d", tag, got, y, exp_y);
          end
        end
        got_y.push_back(y);
        got++;
        occ--;
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back(ref_model(longint'(w_acc[sent]), longint'(w_bias[sent]),
                                  longint'(w_scale[sent]), int'(w_shift[sent])));
        sent++;
        occ++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      prev_y = y;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    cycles = cyc;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s timeout got=%0d exp=%0d words", tag, got, n);
    end
    // Nothing further may come out once all words were drained.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s drain out_valid=%b exp=0", tag, out_valid);
      end
      step();
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state out_valid=%b y=%0d in_ready=%b exp 0 0 1",
               out_valid, y, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_latency();
    acc_in = 1000; bias = 24; scale = 1; shift = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL latency in_ready got=%b exp=1", in_ready);
    end
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (out_valid !== (c == 3)) begin
        errors++;
        $display("FAIL latency out_valid cycle=%0d got=%b exp=%b",
                 c, out_valid, (c == 3));
      end
      if (c < 3) step();
    end
    checks++;
    if (y !== 21'sd1024) begin
      errors++;
      $display("FAIL latency y got=%0d exp=1024", y);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency single_output out_valid=%b exp=0", out_valid);
    end
  endtask

  task automatic test_rounding();
    int cyc;
    logic signed [OUT_W-1:0] exp_tab[4] = '{21'sd2, -21'sd1, 21'sd3, -21'sd2};
    clear_words();
    add_word(3, 0, 1, 1);
    add_word(-3, 0, 1, 1);
    add_word(5, 0, 1, 1);
    add_word(-4, 0, 1, 1);
    run_stream(0, "rounding", cyc);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_y.size() || got_y[i] !== exp_tab[i]) begin
        errors++;
        $display("FAIL rounding_const[%0d] got=%0d exp=%0d", i,
                 (i < got_y.size()) ? got_y[i] : 21'sd0, exp_tab[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int cyc;
    clear_words();
    add_word(64'sd1 <<< 30, 0, 16'hFFFF, 0);
    add_word(-(64'sd1 <<< 31), -1, 1, 0);
    run_stream(0, "saturation", cyc);
    checks++;
    if (got_y.size() != 2 || got_y[0] !== 21'sd1048575 || got_y[1] !== -21'sd1048576) begin
      errors++;
      $display("FAIL saturation got=%0d,%0d exp=1048575,-1048576",
               (got_y.size() > 0) ? got_y[0] : 21'sd0,
               (got_y.size() > 1) ? got_y[1] : 21'sd0);
    end
  endtask

  task automatic test_scale_zero();
    int cyc;
    clear_words();
    add_word(123456, 789, 0, 0);
    add_word(-99999, -5, 0, 7);
    add_word(64'sd2147483647, 64'sd2147483647, 0, 63);
    run_stream(0, "scale_zero", cyc);
    for (int i = 0; i < got_y.size(); i++) begin
      checks++;
      if (got_y[i] !== '0) begin
        errors++;
        $display("FAIL scale_zero[%0d] got=%0d exp=0", i, got_y[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    clear_words();
    for (int i = 0; i < 10; i++)
      add_word(longint'($signed($urandom)) >>> $urandom_range(4, 20),
               longint'($signed($urandom_range(0, 2000))) - 1000,
               100 + i * 977, i + 1);
    run_stream(1, "backpressure", cyc);
    checks++;
    if (!saw_full) begin
      errors++;
      $display("FAIL backpressure in_ready never dropped with 3 words held (got=0 exp=1)");
    end
    checks++;
    if (got_y.size() != 10) begin
      errors++;
      $display("FAIL backpressure count got=%0d exp=10", got_y.size());
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_words();
    for (int i = 0; i < 20; i++)
      add_word(longint'($signed($urandom)), longint'($signed($urandom)),
               $urandom_range(0, 65535), $urandom_range(0, 40));
    run_stream(0, "back_to_back", cyc);
    checks++;
    if (cyc != 23) begin
      errors++;
      $display("FAIL back_to_back cycles got=%0d exp=23", cyc);
    end
  endtask

  task automatic test_random();
    int cyc;
    clear_words();
    for (int i = 0; i < 300; i++)
      add_word(longint'($signed($urandom)) >>> $urandom_range(0, 31),
               longint'($signed($urandom)) >>> $urandom_range(0, 31),
               ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 65535),
               $urandom_range(0, 63));
    run_stream(2, "random", cyc);
  endtask

  task automatic test_reset_midflight();
    logic signed [OUT_W-1:0] exp0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      acc_in = 500 + i; bias = 0; scale = 1; shift = 0;
      step();
    end
    in_valid = 1'b0;
    exp0 = ref_model(500, 0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || y !== exp0) begin
      errors++;
      $display("FAIL reset_mid preload out_valid=%b y=%0d exp 1 %0d",
               out_valid, y, exp0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== '0) begin
      errors++;
      $display("FAIL reset_mid async_clear out_valid=%b y=%0d exp 0 0", out_valid, y);
    end
    step();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid in_ready got=%b exp=1", in_ready);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid stale_word cycle=%0d out_valid=%b exp=0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_scale_zero();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
